// File: rtl/fastann_pkg.sv
// Shared definitions for the FastANN input loader: load-phase state encoding
// and the number of FIFO words that make up one record in each phase.
package fastann_pkg;

    // Load sequencer phases, in the order the FIFO delivers them.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_NODES   = 3'd1,
        ST_LEAVES  = 3'd2,
        ST_QUERIES = 3'd3,
        ST_DONE    = 3'd4
    } load_state_e;

    // Internal node record: split dimension followed by median.
    localparam int unsigned NODE_WORDS = 2;

    // Leaf record: patch words followed by the original-image patch index.
    function automatic int unsigned leaf_words(input int unsigned patch_size);
        return patch_size + 1;
    endfunction

    // Query record: patch words only.
    function automatic int unsigned query_words(input int unsigned patch_size);
        return patch_size;
    endfunction

endpackage

// File: rtl/input_load_ctrl_word_assembler.sv
// word_assembler: collects GROUP_LEN consecutive FIFO words into one record.
// Word 0 of the record ends up in the LSBs.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : discard any partial record
//   en         : a word is being consumed this cycle
//   word       : the word being consumed
//   last_c     : this consumed word completes the record (combinational)
//   group_c    : complete record including the current word (combinational)
module word_assembler #(
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned GROUP_LEN  = 2,
    localparam int unsigned GROUPW    = GROUP_LEN * DATA_WIDTH,
    localparam int unsigned CNTW      = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] word,
    output logic                  last_c,
    output logic [GROUPW-1:0]     group_c
);

    logic [CNTW-1:0] cnt;

    assign last_c = en && (cnt == CNTW'(GROUP_LEN - 1));

    // Position of the next word within the record.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last_c ? '0 : cnt + CNTW'(1);
        end
    end

    generate
        if (GROUP_LEN > 1) begin : g_shift
            // Only the earlier words need storage; the last one is taken live.
            logic [GROUPW-DATA_WIDTH-1:0] held;

            assign group_c = {word, held};

            always_ff @(posedge clk) begin
                if (!rst_n || clear) begin
                    held <= '0;
                end else if (en) begin
                    held <= group_c[GROUPW-1:DATA_WIDTH];
                end
            end
        end else begin : g_single
            assign group_c = word;
        end
    endgenerate

endmodule

// File: rtl/input_load_ctrl.sv
// input_load_ctrl: drains the input FIFO after load_kdtree and distributes the
// word stream into k-d tree internal nodes, leaf patches and query patches.
//   clk, rst_n            : clock, synchronous active-low reset
//   load_kdtree           : start pulse, honoured in IDLE/DONE only
//   fifo_rdata/rempty_n   : FWFT FIFO head word and non-empty flag
//   fifo_deq              : pop the FIFO head this cycle (combinational)
//   node_*                : internal node write port (dim, median)
//   leaf_*                : leaf patch write port (leaf, slot, data, index)
//   query_*               : query patch write port
//   busy                  : a load is in progress
//   kdtree_done           : all leaf patches written (level)
//   queries_done          : all queries written (level)
module input_load_ctrl
    import fastann_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 11,
    parameter int unsigned IDX_WIDTH   = 9,
    parameter int unsigned PATCH_SIZE  = 5,
    parameter int unsigned LEAF_SIZE   = 8,
    parameter int unsigned NUM_LEAVES  = 64,
    parameter int unsigned NUM_QUERYS  = 494,
    localparam int unsigned NUM_NODES  = NUM_LEAVES - 1,
    localparam int unsigned LEAF_ADDRW = $clog2(NUM_LEAVES),
    localparam int unsigned QADDRW     = $clog2(NUM_QUERYS),
    localparam int unsigned SLOTW      = $clog2(LEAF_SIZE),
    localparam int unsigned PATCHW     = PATCH_SIZE * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_kdtree,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_rempty_n,
    output logic                  fifo_deq,
    output logic                  node_wen,
    output logic [LEAF_ADDRW-1:0] node_addr,
    output logic [DATA_WIDTH-1:0] node_dim,
    output logic [DATA_WIDTH-1:0] node_median,
    output logic                  leaf_wen,
    output logic [LEAF_ADDRW-1:0] leaf_addr,
    output logic [SLOTW-1:0]      leaf_slot,
    output logic [PATCHW-1:0]     leaf_wdata,
    output logic [IDX_WIDTH-1:0]  leaf_widx,
    output logic                  query_wen,
    output logic [QADDRW-1:0]     query_addr,
    output logic [PATCHW-1:0]     query_wdata,
    output logic                  busy,
    output logic                  kdtree_done,
    output logic                  queries_done
);

    localparam int unsigned LEAF_WORDS  = leaf_words(PATCH_SIZE);
    localparam int unsigned QUERY_WORDS = query_words(PATCH_SIZE);
    localparam int unsigned NODEGW      = NODE_WORDS * DATA_WIDTH;
    localparam int unsigned LEAFGW      = LEAF_WORDS * DATA_WIDTH;

    load_state_e state;

    logic [LEAF_ADDRW-1:0] node_cnt;
    logic [LEAF_ADDRW-1:0] leaf_cnt;
    logic [SLOTW-1:0]      slot_cnt;
    logic [QADDRW-1:0]     query_cnt;

    logic                  loading;
    logic                  start;
    logic                  node_last;
    logic                  leaf_last;
    logic                  query_last;
    logic [NODEGW-1:0]     node_group;
    logic [LEAFGW-1:0]     leaf_group;
    logic [PATCHW-1:0]     query_group;

    assign loading  = (state == ST_NODES) || (state == ST_LEAVES) || (state == ST_QUERIES);
    assign busy     = loading;
    assign fifo_deq = fifo_rempty_n && loading;
    assign start    = load_kdtree && ((state == ST_IDLE) || (state == ST_DONE));

    // One assembler per phase; each only advances while its phase is active.
    word_assembler #(.DATA_WIDTH(DATA_WIDTH), .GROUP_LEN(NODE_WORDS)) u_node_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start),
        .en      (fifo_deq && (state == ST_NODES)),
        .word    (fifo_rdata),
        .last_c  (node_last),
        .group_c (node_group)
    );

    word_assembler #(.DATA_WIDTH(DATA_WIDTH), .GROUP_LEN(LEAF_WORDS)) u_leaf_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start),
        .en      (fifo_deq && (state == ST_LEAVES)),
        .word    (fifo_rdata),
        .last_c  (leaf_last),
        .group_c (leaf_group)
    );

    word_assembler #(.DATA_WIDTH(DATA_WIDTH), .GROUP_LEN(QUERY_WORDS)) u_query_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start),
        .en      (fifo_deq && (state == ST_QUERIES)),
        .word    (fifo_rdata),
        .last_c  (query_last),
        .group_c (query_group)
    );

    // The index word is wider than the stored index; its top bits are dropped.
    generate
        if (DATA_WIDTH > IDX_WIDTH) begin : g_idx_trunc
            logic unused_idx_hi;
            assign unused_idx_hi = ^leaf_group[LEAFGW-1:PATCHW+IDX_WIDTH];
        end
    endgenerate

    // Load sequencer with registered write ports and completion flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            node_cnt     <= '0;
            leaf_cnt     <= '0;
            slot_cnt     <= '0;
            query_cnt    <= '0;
            node_wen     <= 1'b0;
            node_addr    <= '0;
            node_dim     <= '0;
            node_median  <= '0;
            leaf_wen     <= 1'b0;
            leaf_addr    <= '0;
            leaf_slot    <= '0;
            leaf_wdata   <= '0;
            leaf_widx    <= '0;
            query_wen    <= 1'b0;
            query_addr   <= '0;
            query_wdata  <= '0;
            kdtree_done  <= 1'b0;
            queries_done <= 1'b0;
        end else begin
            node_wen  <= 1'b0;
            leaf_wen  <= 1'b0;
            query_wen <= 1'b0;

            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (load_kdtree) begin
                        state        <= ST_NODES;
                        node_cnt     <= '0;
                        leaf_cnt     <= '0;
                        slot_cnt     <= '0;
                        query_cnt    <= '0;
                        kdtree_done  <= 1'b0;
                        queries_done <= 1'b0;
                    end
                end

                ST_NODES: begin
                    if (node_last) begin
                        node_wen    <= 1'b1;
                        node_addr   <= node_cnt;
                        node_dim    <= node_group[DATA_WIDTH-1:0];
                        node_median <= node_group[NODEGW-1:DATA_WIDTH];
                        if (node_cnt == LEAF_ADDRW'(NUM_NODES - 1)) begin
                            state <= ST_LEAVES;
                        end else begin
                            node_cnt <= node_cnt + LEAF_ADDRW'(1);
                        end
                    end
                end

                ST_LEAVES: begin
                    if (leaf_last) begin
                        leaf_wen   <= 1'b1;
                        leaf_addr  <= leaf_cnt;
                        leaf_slot  <= slot_cnt;
                        leaf_wdata <= leaf_group[PATCHW-1:0];
                        leaf_widx  <= leaf_group[PATCHW +: IDX_WIDTH];
                        if (slot_cnt == SLOTW'(LEAF_SIZE - 1)) begin
                            slot_cnt <= '0;
                            if (leaf_cnt == LEAF_ADDRW'(NUM_LEAVES - 1)) begin
                                kdtree_done <= 1'b1;
                                state       <= ST_QUERIES;
                            end else begin
                                leaf_cnt <= leaf_cnt + LEAF_ADDRW'(1);
                            end
                        end else begin
                            slot_cnt <= slot_cnt + SLOTW'(1);
                        end
                    end
                end

                ST_QUERIES: begin
                    if (query_last) begin
                        query_wen   <= 1'b1;
                        query_addr  <= query_cnt;
                        query_wdata <= query_group;
                        if (query_cnt == QADDRW'(NUM_QUERYS - 1)) begin
                            queries_done <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            query_cnt <= query_cnt + QADDRW'(1);
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_load_ctrl.sv
// Testbench for input_load_ctrl: a FIFO model feeds randomised record streams
// and a record-level reference model predicts every write port and flag.
module tb_input_load_ctrl;

    localparam int DW   = 11;
    localparam int IW   = 9;
    localparam int PS   = 5;
    localparam int LS   = 8;
    localparam int NL   = 64;
    localparam int NQ   = 494;
    localparam int NN   = NL - 1;
    localparam int LAW  = $clog2(NL);
    localparam int QAW  = $clog2(NQ);
    localparam int SW   = $clog2(LS);
    localparam int PW   = PS * DW;
    localparam int NODE_WORDS_TOT = 2 * NN;
    localparam int LEAF_WORDS_TOT = NL * LS * (PS + 1);
    localparam int BUDGET = 12000;

    logic clk;
    logic rst_n;
    logic load_kdtree;
    logic [DW-1:0] fifo_rdata;
    logic fifo_rempty_n;
    logic fifo_deq;
    logic node_wen;
    logic [LAW-1:0] node_addr;
    logic [DW-1:0] node_dim;
    logic [DW-1:0] node_median;
    logic leaf_wen;
    logic [LAW-1:0] leaf_addr;
    logic [SW-1:0] leaf_slot;
    logic [PW-1:0] leaf_wdata;
    logic [IW-1:0] leaf_widx;
    logic query_wen;
    logic [QAW-1:0] query_addr;
    logic [PW-1:0] query_wdata;
    logic busy;
    logic kdtree_done;
    logic queries_done;

    input_load_ctrl #(
        .DATA_WIDTH(DW), .IDX_WIDTH(IW), .PATCH_SIZE(PS),
        .LEAF_SIZE(LS), .NUM_LEAVES(NL), .NUM_QUERYS(NQ)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_kdtree(load_kdtree),
        .fifo_rdata(fifo_rdata), .fifo_rempty_n(fifo_rempty_n), .fifo_deq(fifo_deq),
        .node_wen(node_wen), .node_addr(node_addr), .node_dim(node_dim), .node_median(node_median),
        .leaf_wen(leaf_wen), .leaf_addr(leaf_addr), .leaf_slot(leaf_slot),
        .leaf_wdata(leaf_wdata), .leaf_widx(leaf_widx),
        .query_wen(query_wen), .query_addr(query_addr), .query_wdata(query_wdata),
        .busy(busy), .kdtree_done(kdtree_done), .queries_done(queries_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO contents and, per word, which record (if any) it completes:
    // 0 = mid-record, 1 = node, 2 = leaf patch, 3 = query.
    logic [DW-1:0] stream[$];
    int            tags[$];

    // Expected write records in delivery order, packed as the ports appear.
    logic [LAW+2*DW-1:0]     node_q[$];
    logic [LAW+SW+PW+IW-1:0] leaf_q[$];
    logic [QAW+PW-1:0]       query_q[$];
    logic [LAW+2*DW-1:0]     hold_node;
    logic [LAW+SW+PW+IW-1:0] hold_leaf;
    logic [QAW+PW-1:0]       hold_query;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int popped, leaves_m, queries_m;
    int obs_node, obs_leaf, obs_query;
    int first_pop_cyc, qdone_cyc;
    int empty_pct, stall_at, stall_left;
    int pend_tag;
    bit pend_pop, pend_load;
    bit exp_busy, exp_kd, exp_qd;

    task automatic build_stream(input bit directed);
        logic [DW-1:0] w, a, b;
        logic [PW-1:0] d;
        stream.delete(); tags.delete();
        node_q.delete(); leaf_q.delete(); query_q.delete();
        for (int n = 0; n < NN; n++) begin
            a = DW'($urandom); b = DW'($urandom);
            if (directed && n == 0) begin a = DW'(3); b = DW'(412); end
            stream.push_back(a); tags.push_back(0);
            stream.push_back(b); tags.push_back(1);
            node_q.push_back({LAW'(n), a, b});
        end
        for (int p = 0; p < NL * LS; p++) begin
            d = '0;
            for (int k = 0; k < PS; k++) begin
                w = (directed && p == LS + LS - 1) ? DW'(k + 1) : DW'($urandom);
                d[k*DW +: DW] = w;
                stream.push_back(w); tags.push_back(0);
            end
            w = (directed && p == LS + LS - 1) ? DW'(300) : DW'($urandom);
            stream.push_back(w); tags.push_back(2);
            leaf_q.push_back({LAW'(p / LS), SW'(p % LS), d, w[IW-1:0]});
        end
        for (int q = 0; q < NQ; q++) begin
            d = '0;
            for (int k = 0; k < PS; k++) begin
                w = DW'($urandom);
                d[k*DW +: DW] = w;
                stream.push_back(w); tags.push_back((k == PS - 1) ? 3 : 0);
            end
            query_q.push_back({QAW'(q), d});
        end
        popped = 0;
        obs_node = 0; obs_leaf = 0; obs_query = 0;
        first_pop_cyc = -1; qdone_cyc = -1;
    endtask

    task automatic check_cycle();
        bit en, el, eq;
        en = (pend_tag == 1); el = (pend_tag == 2); eq = (pend_tag == 3);
        n_cmp++;
        if ({node_wen, leaf_wen, query_wen} !== {en, el, eq}) begin
            n_bad++;
            $display("FAIL strobes cyc=%0d got node/leaf/query=%b%b%b expected=%b%b%b",
                     cyc, node_wen, leaf_wen, query_wen, en, el, eq);
        end
        if (en && node_q.size() > 0) hold_node = node_q.pop_front();
        if (el && leaf_q.size() > 0) hold_leaf = leaf_q.pop_front();
        if (eq && query_q.size() > 0) hold_query = query_q.pop_front();
        n_cmp++;
        if ({node_addr, node_dim, node_median} !== hold_node) begin
            n_bad++;
            $display("FAIL node_port cyc=%0d got=%h expected=%h", cyc,
                     {node_addr, node_dim, node_median}, hold_node);
        end
        n_cmp++;
        if ({leaf_addr, leaf_slot, leaf_wdata, leaf_widx} !== hold_leaf) begin
            n_bad++;
            $display("FAIL leaf_port cyc=%0d got=%h expected=%h", cyc,
                     {leaf_addr, leaf_slot, leaf_wdata, leaf_widx}, hold_leaf);
        end
        n_cmp++;
        if ({query_addr, query_wdata} !== hold_query) begin
            n_bad++;
            $display("FAIL query_port cyc=%0d got=%h expected=%h", cyc,
                     {query_addr, query_wdata}, hold_query);
        end
        n_cmp++;
        if ({busy, kdtree_done, queries_done} !== {exp_busy, exp_kd, exp_qd}) begin
            n_bad++;
            $display("FAIL status cyc=%0d got busy/kd/qd=%b%b%b expected=%b%b%b",
                     cyc, busy, kdtree_done, queries_done, exp_busy, exp_kd, exp_qd);
        end
        if (node_wen === 1'b1) obs_node++;
        if (leaf_wen === 1'b1) obs_leaf++;
        if (query_wen === 1'b1) obs_query++;
        if (queries_done === 1'b1 && qdone_cyc < 0) qdone_cyc = cyc;
    endtask

    // One clock: update the model for what happened at the edge, check the
    // outputs, then present the FIFO/inputs for the coming edge.
    task automatic step(input bit ld);
        bit avail;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            stream.delete(); tags.delete();
            node_q.delete(); leaf_q.delete(); query_q.delete();
            pend_pop = 0; pend_load = 0; pend_tag = 0;
            exp_busy = 0; exp_kd = 0; exp_qd = 0;
            hold_node = '0; hold_leaf = '0; hold_query = '0;
        end else begin
            if (pend_load) begin
                exp_busy = 1; exp_kd = 0; exp_qd = 0;
                leaves_m = 0; queries_m = 0;
            end
            pend_tag = 0;
            if (pend_pop) begin
                void'(stream.pop_front());
                pend_tag = tags.pop_front();
                popped++;
            end
            if (pend_tag == 2) begin
                leaves_m++;
                if (leaves_m == NL * LS) exp_kd = 1;
            end
            if (pend_tag == 3) begin
                queries_m++;
                if (queries_m == NQ) begin exp_qd = 1; exp_busy = 0; end
            end
        end
        check_cycle();

        load_kdtree = ld;
        avail = ($urandom_range(99) >= 32'(empty_pct));
        if (stall_left > 0 && popped == stall_at) begin
            avail = 0;
            stall_left--;
        end
        if (!rst_n) avail = 0;
        fifo_rempty_n = avail && (stream.size() > 0);
        fifo_rdata = (stream.size() > 0) ? stream[0] : '0;
        #1;
        n_cmp++;
        if (fifo_deq !== (fifo_rempty_n && exp_busy)) begin
            n_bad++;
            $display("FAIL fifo_deq cyc=%0d got=%b expected=%b", cyc, fifo_deq,
                     fifo_rempty_n && exp_busy);
        end
        if (fifo_deq === 1'b1 && first_pop_cyc < 0) first_pop_cyc = cyc;
        pend_pop  = (fifo_deq === 1'b1) && fifo_rempty_n;
        pend_load = ld && !exp_busy && rst_n;
    endtask

    task automatic run_load(input bit directed, input int pct, input int stall_i,
                            input int ld_at, input int abort_at);
        bit ld_done;
        bit ld;
        ld_done = 0;
        build_stream(directed);
        empty_pct = pct; stall_at = stall_i; stall_left = 10;
        step(1);
        for (int i = 0; i < BUDGET; i++) begin
            if (abort_at >= 0 && popped >= abort_at) begin
                rst_n = 0; step(0); step(0);
                rst_n = 1; step(0);
                return;
            end
            ld = (ld_at >= 0) && !ld_done && (popped >= ld_at);
            if (ld) ld_done = 1;
            step(ld);
            if (exp_qd) break;
        end
        n_cmp++;
        if (!exp_qd) begin
            n_bad++;
            $display("FAIL load_timeout popped=%0d expected=%0d words", popped,
                     NODE_WORDS_TOT + LEAF_WORDS_TOT + NQ * PS);
        end
        step(0);
    endtask

    task automatic check_counts(input string name);
        n_cmp++;
        if ({obs_node, obs_leaf, obs_query} !== {NN, NL * LS, NQ}) begin
            n_bad++;
            $display("FAIL %s_counts got node/leaf/query=%0d/%0d/%0d expected=%0d/%0d/%0d",
                     name, obs_node, obs_leaf, obs_query, NN, NL * LS, NQ);
        end
        n_cmp++;
        if (stream.size() != 0 || node_q.size() != 0 || leaf_q.size() != 0 || query_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_leftover got words=%0d recs=%0d expected=0", name,
                     stream.size(), node_q.size() + leaf_q.size() + query_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        step(0);
        step(1);
        step(0);
        n_cmp++;
        if ({node_addr, node_dim, node_median, leaf_addr, leaf_slot, leaf_widx, query_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_addr_fields got=%h expected=0",
                     {node_addr, node_dim, node_median, leaf_addr, leaf_slot, leaf_widx, query_addr});
        end
        n_cmp++;
        if ({leaf_wdata, query_wdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_data got=%h expected=0", {leaf_wdata, query_wdata});
        end
        n_cmp++;
        if ({fifo_deq, busy, kdtree_done, queries_done, node_wen, leaf_wen, query_wen} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl got=%b expected=0000000",
                     {fifo_deq, busy, kdtree_done, queries_done, node_wen, leaf_wen, query_wen});
        end
        rst_n = 1;
        step(0);
    endtask

    task automatic test_full_load();
        run_load(0, 0, -1, -1, -1);
        check_counts("full");
        // Inclusive span from the first pop cycle to the cycle queries_done is seen.
        n_cmp++;
        if (qdone_cyc - first_pop_cyc + 1 != 5669) begin
            n_bad++;
            $display("FAIL full_latency got=%0d expected=5669", qdone_cyc - first_pop_cyc + 1);
        end
    endtask

    task automatic test_directed_stall();
        run_load(1, 0, NODE_WORDS_TOT + LEAF_WORDS_TOT + 10 * PS + 3, -1, -1);
        check_counts("stall");
    endtask

    task automatic test_load_ignored();
        run_load(0, 20, -1, NODE_WORDS_TOT + 600, -1);
        check_counts("load_ignored");
    endtask

    task automatic test_reset_mid_leaf();
        run_load(0, 0, -1, -1, NODE_WORDS_TOT + (PS + 1) * 20 + 3);
        n_cmp++;
        if ({busy, kdtree_done, leaf_wen} !== 3'b000) begin
            n_bad++;
            $display("FAIL abort_state got busy/kd/wen=%b%b%b expected=000",
                     busy, kdtree_done, leaf_wen);
        end
        run_load(0, 30, -1, -1, -1);
        check_counts("reload");
    endtask

    initial begin
        rst_n = 0;
        load_kdtree = 0;
        fifo_rempty_n = 0;
        fifo_rdata = '0;
        pend_pop = 0; pend_load = 0; pend_tag = 0;
        exp_busy = 0; exp_kd = 0; exp_qd = 0;
        hold_node = '0; hold_leaf = '0; hold_query = '0;
        empty_pct = 0; stall_at = -1; stall_left = 0;
        popped = 0; leaves_m = 0; queries_m = 0;
        first_pop_cyc = -1; qdone_cyc = -1;
        obs_node = 0; obs_leaf = 0; obs_query = 0;

        test_reset();
        test_full_load();
        test_directed_stall();
        test_load_ignored();
        test_reset_mid_leaf();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_load_ctrl.md
INPUT_LOAD_CTRL -- requirements
Module: input_load_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11, input word width.
REQ-002 SHALL have parameter IDX_WIDTH, default 9, original-image patch index width.
REQ-003 SHALL have parameter PATCH_SIZE, default 5, data words per patch.
REQ-004 SHALL have parameter LEAF_SIZE, default 8, patches per leaf.
REQ-005 SHALL have parameter NUM_LEAVES, default 64; NUM_NODES = NUM_LEAVES-1; LEAF_ADDRW = $clog2(NUM_LEAVES).
REQ-006 SHALL have parameter NUM_QUERYS, default 494; QADDRW = $clog2(NUM_QUERYS).
REQ-007 SHALL have ports as follows; one clock; reset is synchronous and active-low.
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- load_kdtree  in  1  start pulse
- fifo_rdata  in  DATA_WIDTH  input FIFO head word (first-word-fall-through)
- fifo_rempty_n  in  1  FIFO non-empty
- fifo_deq  out  1  pop FIFO head this cycle
- node_wen  out  1  internal-node write strobe
- node_addr  out  LEAF_ADDRW  node number 0..NUM_NODES-1
- node_dim  out  DATA_WIDTH  split dimension (1st word of node)
- node_median  out  DATA_WIDTH  median (2nd word of node)
- leaf_wen  out  1  leaf patch write strobe
- leaf_addr  out  LEAF_ADDRW  leaf number
- leaf_slot  out  $clog2(LEAF_SIZE)  patch slot within leaf
- leaf_wdata  out  PATCH_SIZE*DATA_WIDTH  patch data, word 0 in LSBs
- leaf_widx  out  IDX_WIDTH  patch index (6th word, low IDX_WIDTH bits)
- query_wen  out  1  query patch write strobe
- query_addr  out  QADDRW  query number
- query_wdata  out  PATCH_SIZE*DATA_WIDTH  query data, word 0 in LSBs
- busy  out  1  state != IDLE and != DONE
- kdtree_done  out  1  level, set when last leaf patch written
- queries_done  out  1  level, set when last query written

Function
REQ-008 SHALL implement FSM states IDLE, NODES, LEAVES, QUERIES, DONE.
REQ-009 IDLE/DONE: load_kdtree=1 -> NODES next cycle, all counters zeroed, kdtree_done and queries_done cleared; load_kdtree ignored in NODES/LEAVES/QUERIES.
REQ-010 fifo_deq SHALL equal fifo_rempty_n in NODES/LEAVES/QUERIES, 0 otherwise (combinational); a word is consumed only when fifo_deq=1.
REQ-011 NODES: word pairs (dim, median); node_wen pulses one cycle, registered, the cycle after the median is consumed, with node_addr = pair count.
REQ-012 After pair NUM_NODES-1 is consumed, FSM SHALL enter LEAVES next cycle.
REQ-013 LEAVES: groups of PATCH_SIZE+1 words; first PATCH_SIZE shifted into leaf_wdata, last into leaf_widx; leaf_wen pulses the cycle after the group's last word.
REQ-014 leaf_slot increments per patch, wraps LEAF_SIZE-1 -> 0 and then increments leaf_addr.
REQ-015 After patch (NUM_LEAVES-1, LEAF_SIZE-1) is consumed: kdtree_done set, FSM enters QUERIES.
REQ-016 QUERIES: groups of PATCH_SIZE words -> query_wdata; query_wen pulses the cycle after the last word; query_addr increments 0..NUM_QUERYS-1.
REQ-017 After query NUM_QUERYS-1 is consumed: queries_done set, FSM enters DONE.
REQ-018 Empty FIFO mid-group SHALL stall without losing partial words; no timeout.
REQ-019 Write strobes SHALL be mutually exclusive and never asserted in IDLE.
REQ-020 Data/address outputs SHALL hold last written value between strobes.

Reset
REQ-021 rst_n=0 at a clock edge SHALL force IDLE; all counters, strobes, fifo_deq, busy, kdtree_done, queries_done, data/address outputs to 0.
REQ-022 Reset mid-load SHALL discard any partial patch/node; no write strobe in the cycle after reset.

Structure
REQ-023 State enum and word-per-record constants (2, PATCH_SIZE+1, PATCH_SIZE) SHALL live in shared package fastann_pkg.
REQ-024 One sub-module, word_assembler (word counter + shift register, parameterised group length), SHALL be reused by all three load phases.

Verification
REQ-025 Full load, FIFO always non-empty: 126 node + 3072 leaf + 2470 query words -> 63 node_wen, 512 leaf_wen, 494 query_wen, queries_done 5669 cycles after first pop.
REQ-026 Node 0 words 3, 412 -> node_wen with node_addr=0, node_dim=3, node_median=412.
REQ-027 Leaf 1 slot 7 words 1..5, 300 -> leaf_addr=1, leaf_slot=7, leaf_wdata words 1..5, leaf_widx=300.
REQ-028 FIFO empty 10 cycles after word 3 of a query -> fifo_deq low, no query_wen, resumed data intact.
REQ-029 load_kdtree pulsed during LEAVES -> ignored, counters unchanged.
REQ-030 rst_n low mid-leaf, then reload -> first leaf_wen has leaf_addr=0, leaf_slot=0, kdtree_done=0 until end.
